// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite bus bundle: AW/W/B write channels and AR/R read channels.
interface AXI_LITE #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
);
  logic                          aw_valid;
  logic                          aw_ready;
  logic [AXI_ADDR_WIDTH-1:0]     aw_addr;
  logic                          w_valid;
  logic                          w_ready;
  logic [AXI_DATA_WIDTH-1:0]     w_data;
  logic [AXI_DATA_WIDTH/8-1:0]   w_strb;
  logic                          b_valid;
  logic                          b_ready;
  logic [1:0]                    b_resp;
  logic                          ar_valid;
  logic                          ar_ready;
  logic [AXI_ADDR_WIDTH-1:0]     ar_addr;
  logic                          r_valid;
  logic                          r_ready;
  logic [AXI_DATA_WIDTH-1:0]     r_data;
  logic [1:0]                    r_resp;

  modport in (
    input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport out (
    output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite responder backed by a bank of NUM_REGS byte-strobed registers.
// Out-of-range word indices answer SLVERR; register contents are exported on regs_o.
module axi_lite_reg_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  AXI_LITE.in                            in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned CMP_W  = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Elaboration-time parameter sanity checks.
  if (DATA_WIDTH < 8 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_dw
    $error("axi_lite_reg_slave: DATA_WIDTH must be a power of two >= 8");
  end
  if (NUM_REGS < 1) begin : g_bad_nr
    $error("axi_lite_reg_slave: NUM_REGS must be at least 1");
  end
  if ($bits(in.aw_addr) != ADDR_WIDTH || $bits(in.w_data) != DATA_WIDTH) begin : g_bad_if
    $error("axi_lite_reg_slave: interface widths do not match parameters");
  end

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  r_aw_held;
  logic                  r_w_held;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [STRB_W-1:0]     r_w_strb;
  logic                  r_b_valid;
  logic [1:0]            r_b_resp;
  logic                  r_r_valid;
  logic [DATA_WIDTH-1:0] r_r_data;
  logic [1:0]            r_r_resp;

  logic                  w_aw_ready;
  logic                  w_w_ready;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [STRB_W-1:0]     w_wr_strb;
  logic [CMP_W-1:0]      w_wr_idx;
  logic                  w_wr_ok;
  logic [CMP_W-1:0]      w_rd_idx;
  logic                  w_rd_ok;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Readies are pure functions of held state, never of bus inputs.
  assign w_aw_ready = !r_aw_held && !r_b_valid;
  assign w_w_ready  = !r_w_held && !r_b_valid;
  assign w_aw_hs    = in.aw_valid && w_aw_ready;
  assign w_w_hs     = in.w_valid && w_w_ready;
  assign w_ar_hs    = in.ar_valid && !r_r_valid;
  assign w_commit   = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

  assign w_wr_addr  = r_aw_held ? r_aw_addr : in.aw_addr;
  assign w_wr_data  = r_w_held ? r_w_data : in.w_data;
  assign w_wr_strb  = r_w_held ? r_w_strb : in.w_strb;
  assign w_wr_idx   = CMP_W'(w_wr_addr >> OFF_W);
  assign w_wr_ok    = w_wr_idx < CMP_W'(NUM_REGS);
  assign w_rd_idx   = CMP_W'(in.ar_addr >> OFF_W);
  assign w_rd_ok    = w_rd_idx < CMP_W'(NUM_REGS);

  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_rd_idx == CMP_W'(k)) w_rd_data = r_regs[k];
    end
  end

  // Write path: independent AW/W capture, commit once both are present.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_b_valid <= 1'b0;
      r_b_resp  <= RESP_OKAY;
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
    end else begin
      if (r_b_valid && in.b_ready) r_b_valid <= 1'b0;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_b_valid <= 1'b1;
        r_b_resp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (w_wr_ok && w_wr_idx == CMP_W'(k)) begin
            for (int b = 0; b < STRB_W; b++) begin
              if (w_wr_strb[b]) r_regs[k][b*8 +: 8] <= w_wr_data[b*8 +: 8];
            end
          end
        end
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_aw_addr <= in.aw_addr;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_w_data <= in.w_data;
          r_w_strb <= in.w_strb;
        end
      end
    end
  end

  // Read path: sample the pre-update register value on the AR handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_r_valid <= 1'b0;
      r_r_data  <= '0;
      r_r_resp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_r_valid <= 1'b1;
      r_r_data  <= w_rd_ok ? w_rd_data : '0;
      r_r_resp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_r_valid && in.r_ready) begin
      r_r_valid <= 1'b0;
    end
  end

  assign in.aw_ready = w_aw_ready;
  assign in.w_ready  = w_w_ready;
  assign in.b_valid  = r_b_valid;
  assign in.b_resp   = r_b_resp;
  assign in.ar_ready = !r_r_valid;
  assign in.r_valid  = r_r_valid;
  assign in.r_data   = r_r_data;
  assign in.r_resp   = r_r_resp;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
    assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[k];
  end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: directed scenarios plus random traffic against a word-array model.
module tb_axi_lite_reg_slave;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 8;
  localparam int unsigned TO = 32;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [NR*DW-1:0]  regs_o;
  logic [31:0]       mdl [NR];
  int                n_checks = 0;
  int                n_errors = 0;

  AXI_LITE #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();

  axi_lite_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .in     (bus),
    .regs_o (regs_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] model_vec();
    logic [NR*DW-1:0] v;
    for (int k = 0; k < NR; k++) v[k*DW +: DW] = mdl[k];
    return v;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    int unsigned idx;
    idx = addr / 4;
    if (idx < NR) begin
      for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
      resp = 2'b00;
    end else begin
      resp = 2'b10;
    end
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int unsigned idx;
    idx = addr / 4;
    if (idx < NR) begin data = mdl[idx]; resp = 2'b00; end
    else          begin data = 32'h0;    resp = 2'b10; end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lead > 0: W is offered lead cycles before AW; lead < 0: AW leads.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input int bp, input bit release_b);
    int aw_at, w_at;
    bit aw_done, w_done, aw_rdy, w_rdy;
    logic [1:0] er;
    aw_at = (lead > 0) ? lead : 0;
    w_at  = (lead < 0) ? -lead : 0;
    aw_done = 1'b0;
    w_done  = 1'b0;
    for (int cyc = 0; cyc <= TO; cyc++) begin
      if (cyc == TO) begin
        check_eq("wr_timeout", 1, 0);
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
        return;
      end
      if (cyc == aw_at) begin bus.aw_valid = 1'b1; bus.aw_addr = addr; end
      if (cyc == w_at) begin bus.w_valid = 1'b1; bus.w_data = data; bus.w_strb = strb; end
      if (w_done && !aw_done) check_eq("w_ready_while_held", bus.w_ready, 0);
      if (aw_done && !w_done) check_eq("aw_ready_while_held", bus.aw_ready, 0);
      aw_rdy = bus.aw_ready;
      w_rdy  = bus.w_ready;
      tick();
      if (bus.aw_valid && aw_rdy) begin bus.aw_valid = 1'b0; aw_done = 1'b1; end
      if (bus.w_valid && w_rdy) begin bus.w_valid = 1'b0; w_done = 1'b1; end
      if (aw_done && w_done) break;
    end
    model_write(addr, data, strb, er);
    check_eq("b_valid_after_commit", bus.b_valid, 1);
    check_eq("b_resp", bus.b_resp, er);
    check_eq("regs_after_write", regs_o, model_vec());
    for (int i = 0; i < bp; i++) begin
      check_eq("b_valid_hold", bus.b_valid, 1);
      check_eq("b_resp_hold", bus.b_resp, er);
      check_eq("awready_wready_blocked", {bus.aw_ready, bus.w_ready}, 0);
      tick();
    end
    if (release_b) begin
      bus.b_ready = 1'b1;
      tick();
      bus.b_ready = 1'b0;
      check_eq("b_valid_drop", bus.b_valid, 0);
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input int bp);
    logic [31:0] ed;
    logic [1:0]  er;
    bit rdy;
    model_read(addr, ed, er);
    bus.ar_valid = 1'b1;
    bus.ar_addr  = addr;
    for (int cyc = 0; cyc <= TO; cyc++) begin
      if (cyc == TO) begin
        check_eq("rd_timeout", 1, 0);
        bus.ar_valid = 1'b0;
        return;
      end
      rdy = bus.ar_ready;
      tick();
      if (rdy) break;
    end
    bus.ar_valid = 1'b0;
    check_eq("r_valid", bus.r_valid, 1);
    check_eq("r_data", bus.r_data, ed);
    check_eq("r_resp", bus.r_resp, er);
    for (int i = 0; i < bp; i++) begin
      check_eq("r_hold", {bus.r_valid, bus.r_resp, bus.r_data}, {1'b1, er, ed});
      check_eq("ar_ready_blocked", bus.ar_ready, 0);
      tick();
    end
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
    check_eq("r_valid_drop", bus.r_valid, 0);
  endtask

  task automatic check_idle_after_reset();
    check_eq("rst_regs", regs_o, 0);
    check_eq("rst_b_valid", bus.b_valid, 0);
    check_eq("rst_r_valid", bus.r_valid, 0);
    check_eq("rst_readies", {bus.aw_ready, bus.w_ready, bus.ar_ready}, 3'b111);
  endtask

  initial begin
    logic [1:0] er;
    bus.aw_valid = 1'b0; bus.aw_addr = '0;
    bus.w_valid  = 1'b0; bus.w_data  = '0; bus.w_strb = '0;
    bus.b_ready  = 1'b0;
    bus.ar_valid = 1'b0; bus.ar_addr = '0;
    bus.r_ready  = 1'b0;
    for (int k = 0; k < NR; k++) mdl[k] = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    check_idle_after_reset();

    // Same-cycle AW/W full write, then read back.
    axi_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 1'b1);
    axi_read(32'h04, 0);

    // Strobed write with W three cycles ahead of AW.
    axi_write(32'h08, 32'h11223344, 4'hF, 0, 0, 1'b1);
    axi_write(32'h08, 32'hAABBCCDD, 4'b0101, 3, 0, 1'b1);
    check_eq("reg2_strobed", regs_o[2*DW +: DW], 32'h11BB33DD);

    // AW ahead of W.
    axi_write(32'h0C, 32'h01020304, 4'b1010, -2, 0, 1'b1);

    // Out-of-range accesses.
    axi_write(32'h20, 32'hCAFEF00D, 4'hF, 0, 0, 1'b1);
    axi_read(32'h3C, 0);

    // Backpressure on B and R.
    axi_write(32'h10, 32'h55AA55AA, 4'hF, 1, 5, 1'b1);
    axi_read(32'h10, 5);

    // Read and write commit to reg1 in the same cycle.
    axi_write(32'h04, 32'h9, 4'hF, 0, 0, 1'b1);
    bus.aw_valid = 1'b1; bus.aw_addr = 32'h04;
    bus.w_valid  = 1'b1; bus.w_data  = 32'h5; bus.w_strb = 4'hF;
    bus.ar_valid = 1'b1; bus.ar_addr = 32'h04;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
    model_write(32'h04, 32'h5, 4'hF, er);
    check_eq("collide_r_data_old", {bus.r_valid, bus.r_data}, {1'b1, 32'h9});
    check_eq("collide_b", {bus.b_valid, bus.b_resp}, {1'b1, er});
    check_eq("collide_regs", regs_o, model_vec());
    bus.b_ready = 1'b1; bus.r_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0; bus.r_ready = 1'b0;
    check_eq("collide_drop", {bus.b_valid, bus.r_valid}, 2'b00);
    axi_read(32'h04, 0);

    // Random traffic against the model.
    for (int it = 0; it < 80; it++) begin
      logic [31:0] addr;
      addr = {26'($urandom_range(0, 11)), 2'($urandom), 2'b00} >> 2;
      addr = (32'($urandom_range(0, 11)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h100;
      if ($urandom_range(0, 1) == 0)
        axi_write(addr, $urandom, 4'($urandom), $urandom_range(0, 6) - 3, $urandom_range(0, 2), 1'b1);
      else
        axi_read(addr, $urandom_range(0, 2));
    end
    check_eq("regs_after_random", regs_o, model_vec());

    // Reset while a write response is pending.
    axi_write(32'h18, 32'h12345678, 4'hF, 0, 0, 1'b0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < NR; k++) mdl[k] = 32'h0;
    check_idle_after_reset();
    axi_read(32'h18, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
